lfsr_rng_arbiter: RTL and testbench

//  Shares one XNOR-feedback Fibonacci LFSR between NREQ requesters with a round-robin arbiter.
//  The winner's LFSR is stepped OUT_BITS times, and the feedback bits are packed serially into one word.
//  The word is returned with the winner's ID. Sits between the game/test logic and the bit-serial LFSR.

---
 rtl/lfsr_rng_pkg.sv | 24 ++
 rtl/lfsr_rng_arbiter_core.sv | 33 +++
 rtl/lfsr_rng_arbiter.sv | 95 +++++++++
 tb/tb_lfsr_rng_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_rng_pkg.sv
// lfsr_rng_pkg: shared types, default parameters and round-robin pick for lfsr_rng_arbiter
package lfsr_rng_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int WIDTH_D    = 10;
  localparam int X1_D       = 6;
  localparam int X2_D       = 9;
  localparam int OUT_BITS_D = 8;
  localparam int NREQ_D     = 4;
  localparam int MAX_REQ    = 64;
  // First set bit of req at or after ptr, wrapping at n. Scanning from the far
  // end down lets the closest candidate overwrite the earlier ones.
  function automatic logic [5:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [5:0] ptr, input int n);
    logic [5:0] pick;
    logic [6:0] s;
    logic [5:0] idx;
    pick = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      s   = 7'(ptr) + 7'(i);
      idx = s >= 7'(n) ? 6'(s - 7'(n)) : s[5:0];
      if (i < n && req[idx]) pick = idx;
    end
    return pick;
  endfunction
endpackage

// File: rtl/lfsr_rng_arbiter_core.sv
// lfsr_step_core: XNOR Fibonacci LFSR register with seed load and single-step control
//   clk, reset_n : clock, asynchronous active-low reset (q clears to 0)
//   step         : advance one position, q <= {q[WIDTH-2:0], fb}
//   load/load_val: overwrite q with load_val (load wins over step)
//   fb           : current feedback bit q[X1] ~^ q[X2]
//   q            : LFSR state
// Macro LFSR_LOCKUP_GUARD_EN: keeps q out of the all-ones lockup state.
module lfsr_step_core #(
  parameter int WIDTH = 10,
  parameter int X1    = 6,
  parameter int X2    = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             fb,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_d;
  assign fb = q[X1] ~^ q[X2];
`ifdef LFSR_LOCKUP_GUARD_EN
  // At all-ones fb is already 1, so only the register needs forcing to zero.
  always_comb q_d = load ? (&load_val ? '0 : load_val) : step ? (&q ? '0 : {q[WIDTH-2:0], fb}) : q;
`else
  always_comb q_d = load ? load_val : step ? {q[WIDTH-2:0], fb} : q;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else q <= q_d;
  end
endmodule

// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: round-robin shared LFSR delivering OUT_BITS-bit random words
//   clk, reset_n  : clock, asynchronous active-low reset
//   req           : level requests, one per requester
//   gnt           : one-hot grant held for SHIFT and DONE
//   busy          : transaction in progress
//   rnd_valid     : one-cycle pulse qualifying rnd_data/rnd_id
//   rnd_data      : random word, first generated bit in MSB
//   rnd_id        : granted requester index
//   seed_load/val : load LFSR seed, honoured only in IDLE
// Macro LFSR_LOCKUP_GUARD_EN enables the all-ones lockup guard in lfsr_step_core.
module lfsr_rng_arbiter
  import lfsr_rng_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int X1       = X1_D,
  parameter int X2       = X2_D,
  parameter int OUT_BITS = OUT_BITS_D,
  parameter int NREQ     = NREQ_D
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    rnd_valid,
  output logic [OUT_BITS-1:0]     rnd_data,
  output logic [$clog2(NREQ)-1:0] rnd_id,
  input  logic                    seed_load,
  input  logic [WIDTH-1:0]        seed_val
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(OUT_BITS);
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OUT_BITS-1:0] word_q, word_d, rnd_data_q, rnd_data_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]    rnd_id_q, rnd_id_d, rr_ptr_q, rr_ptr_d, pick;
  logic              fb, step, load, grant, last;
  logic [WIDTH-1:0]  lfsr_q;
  logic              unused_q;
  assign unused_q = ^lfsr_q;
  lfsr_step_core #(.WIDTH(WIDTH), .X1(X1), .X2(X2)) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .step     (step),
    .load     (load),
    .load_val (seed_val),
    .fb       (fb),
    .q        (lfsr_q)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      gnt_q      <= '0;
      rnd_id_q   <= '0;
      rnd_data_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      gnt_q      <= gnt_d;
      rnd_id_q   <= rnd_id_d;
      rnd_data_q <= rnd_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end
  // seed_load takes the IDLE cycle, so a request waits one cycle behind it
  always_comb begin
    grant   = state_q == IDLE && !seed_load && |req;
    last    = cnt_q == CW'(OUT_BITS - 1);
    state_d = state_q == IDLE ? (grant ? SHIFT : IDLE) : state_q == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    pick       = IDW'(rr_pick(MAX_REQ'(req), 6'(rr_ptr_q), NREQ));
    step       = state_q == SHIFT;
    load       = state_q == IDLE && seed_load;
    cnt_d      = grant ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    word_d     = grant ? '0 : step ? {word_q[OUT_BITS-2:0], fb} : word_q;
    gnt_d      = grant ? NREQ'(1) << pick : state_q == DONE ? '0 : gnt_q;
    rnd_id_d   = grant ? pick : rnd_id_q;
    // capture the completed word on the final shift so it is ready in DONE and holds afterwards
    rnd_data_d = step && last ? {word_q[OUT_BITS-2:0], fb} : rnd_data_q;
    rr_ptr_d   = state_q == DONE ? (rnd_id_q == IDW'(NREQ - 1) ? '0 : rnd_id_q + 1'b1) : rr_ptr_q;
  end
  always_comb begin
    busy      = state_q != IDLE;
    rnd_valid = state_q == DONE;
    gnt       = gnt_q;
    rnd_id    = rnd_id_q;
    rnd_data  = rnd_data_q;
  end
endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// tb_lfsr_rng_arbiter: directed self-checking bench for lfsr_rng_arbiter
module tb_lfsr_rng_arbiter;
  logic       clk = 0, reset_n = 0, seed_load = 0;
  logic [3:0] req = '0, gnt;
  logic       busy, rnd_valid, seen;
  logic [7:0] rnd_data, w;
  logic [1:0] rnd_id;
  logic [9:0] seed_val = '0, mq = '0;
  int         checks = 0, failures = 0, n;
  lfsr_rng_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .busy      (busy),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .rnd_id    (rnd_id),
    .seed_load (seed_load),
    .seed_val  (seed_val)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 0;
    req = '0;
    seed_load = 0;
    tick();
    reset_n = 1;
    mq = '0;
  endtask
  task automatic wait_valid(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!rnd_valid && k < 40);
    chk("valid_seen", 32'(rnd_valid), 1);
  endtask
  task automatic model_word(output logic [7:0] o);
    logic f;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      f = mq[6] ~^ mq[9];
`ifdef LFSR_LOCKUP_GUARD_EN
      mq = &mq ? '0 : {mq[8:0], f};
`else
      mq = {mq[8:0], f};
`endif
      o = {o[6:0], f};
    end
  endtask
  initial begin
    do_reset();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(rnd_valid), 0);
    chk("rst_data", 32'(rnd_data), 0);
    chk("rst_id", 32'(rnd_id), 0);
    req = 4'b0001;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 1) req = '0;
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_valid", 32'(rnd_valid), 32'(i == 9));
    end
    chk("t1_data", 32'(rnd_data), 32'hFE);
    chk("t1_id", 32'(rnd_id), 0);
    tick();
    chk("t1_gnt_off", 32'(gnt), 0);
    chk("t1_busy_off", 32'(busy), 0);
    chk("t1_valid_off", 32'(rnd_valid), 0);
    chk("t1_data_hold", 32'(rnd_data), 32'hFE);
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_valid(n);
      model_word(w);
      chk("t2_id", 32'(rnd_id), 32'(t % 4));
      chk("t2_data", 32'(rnd_data), 32'(w));
      chk("t2_gap", n, t == 0 ? 9 : 10);
    end
    req = '0;
    tick();
    chk("t2_idle", 32'(busy), 0);
    seed_load = 1;
    seed_val = '0;
    req = 4'b0001;
    tick();
    seed_load = 0;
    chk("t3_no_gnt", 32'(gnt), 0);
    chk("t3_no_busy", 32'(busy), 0);
    tick();
    chk("t3_gnt", 32'(gnt), 32'h1);
    req = '0;
    wait_valid(n);
    chk("t3_gap", n, 8);
    chk("t3_data", 32'(rnd_data), 32'hFE);
    chk("t3_id", 32'(rnd_id), 0);
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    seed_load = 1;
    seed_val = 10'h155;
    tick();
    tick();
    seed_load = 0;
    wait_valid(n);
    model_word(w);
    chk("t4_gap", n, 6);
    chk("t4_data", 32'(rnd_data), 32'(w));
    chk("t4_data_fe", 32'(rnd_data), 32'hFE);
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    tick();
    tick();
    chk("t5_busy_pre", 32'(busy), 1);
    reset_n = 0;
    #1;
    chk("t5_gnt", 32'(gnt), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid", 32'(rnd_valid), 0);
    chk("t5_data", 32'(rnd_data), 0);
    chk("t5_id", 32'(rnd_id), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= rnd_valid;
    end
    chk("t5_no_valid", 32'(seen), 0);
    reset_n = 1;
    mq = '0;
    req = 4'b0010;
    wait_valid(n);
    req = '0;
    model_word(w);
    chk("t5_id_after", 32'(rnd_id), 1);
    chk("t5_data_after", 32'(rnd_data), 32'hFE);
    do_reset();
    seed_load = 1;
    seed_val = 10'h3FF;
    tick();
    seed_load = 0;
`ifdef LFSR_LOCKUP_GUARD_EN
    mq = '0;
`else
    mq = 10'h3FF;
`endif
    req = 4'b0001;
    wait_valid(n);
    req = '0;
    model_word(w);
`ifdef LFSR_LOCKUP_GUARD_EN
    chk("t6_data1", 32'(rnd_data), 32'hFE);
`else
    chk("t6_data1", 32'(rnd_data), 32'hFF);
`endif
    chk("t6_data1_model", 32'(rnd_data), 32'(w));
    tick();
    req = 4'b0001;
    wait_valid(n);
    req = '0;
    model_word(w);
    chk("t6_data2", 32'(rnd_data), 32'(w));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
